// File: rtl/amt_pkg.sv
// Shared definitions for the multi-channel timer: register offsets, CONTROL/STATUS
// bit positions, the PRESC field bounds and the per-channel readback state.
package amt_pkg;

  typedef enum logic [1:0] {
    REG_STATUS  = 2'd0,
    REG_CONTROL = 2'd1,
    REG_PERIOD  = 2'd2,
    REG_SNAP    = 2'd3
  } reg_off_e;

  localparam int STATUS_TO_BIT  = 0;
  localparam int STATUS_RUN_BIT = 1;

  localparam int CTRL_ITO_BIT   = 0;
  localparam int CTRL_CONT_BIT  = 1;
  localparam int CTRL_START_BIT = 2;
  localparam int CTRL_STOP_BIT  = 3;

  localparam int PRESC_LSB = 8;
  localparam int PRESC_MSB = 15;
  localparam int PRESC_W   = PRESC_MSB - PRESC_LSB + 1;

  // Registered state of one channel as seen by the bus read mux.
  typedef struct packed {
    logic               to;
    logic               run;
    logic               ito;
    logic               cont;
    logic [PRESC_W-1:0] presc;
  } ch_state_t;

  function automatic logic [31:0] pack_status(input ch_state_t s);
    logic [31:0] v;
    v = '0;
    v[STATUS_TO_BIT]  = s.to;
    v[STATUS_RUN_BIT] = s.run;
    return v;
  endfunction

  function automatic logic [31:0] pack_control(input ch_state_t s);
    logic [31:0] v;
    v = '0;
    v[CTRL_ITO_BIT]            = s.ito;
    v[CTRL_CONT_BIT]           = s.cont;
    v[PRESC_MSB:PRESC_LSB]     = s.presc;
    return v;
  endfunction

endpackage

// File: rtl/amt_channel.sv
// One independent timer channel: prescaler, down-counter with reload, RUN/TO flags
// and a bus-triggered snapshot of the live count.
module amt_channel
  import amt_pkg::*;
#(
  parameter int CNT_W      = 32,
  parameter int RST_PERIOD = 49999
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             wr_i,
  input  reg_off_e         off_i,
  input  logic [31:0]      wdata_i,
  output ch_state_t        state_o,
  output logic [CNT_W-1:0] period_o,
  output logic [CNT_W-1:0] snap_o,
  output logic             irq_o
);

  localparam logic [CNT_W-1:0] RST_VAL = CNT_W'(RST_PERIOD);

  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [CNT_W-1:0]   period_q, period_d;
  logic [CNT_W-1:0]   snap_q, snap_d;
  logic [PRESC_W-1:0] presc_q, presc_d;
  logic [PRESC_W-1:0] pcnt_q, pcnt_d;
  logic               run_q, run_d;
  logic               to_q, to_d;
  logic               ito_q, ito_d;
  logic               cont_q, cont_d;
  logic               load_q, load_d;

  logic wr_status, wr_control, wr_period, wr_snap;
  logic start, stop, tick, timeout;

  assign wr_status  = wr_i && (off_i == REG_STATUS);
  assign wr_control = wr_i && (off_i == REG_CONTROL);
  assign wr_period  = wr_i && (off_i == REG_PERIOD);
  assign wr_snap    = wr_i && (off_i == REG_SNAP);

  assign start   = wr_control && wdata_i[CTRL_START_BIT];
  assign stop    = wr_control && wdata_i[CTRL_STOP_BIT];
  assign tick    = run_q && (pcnt_q == presc_q);
  assign timeout = tick && (cnt_q == '0);

  always_comb begin
    cnt_d    = cnt_q;
    period_d = period_q;
    snap_d   = snap_q;
    presc_d  = presc_q;
    pcnt_d   = pcnt_q;
    run_d    = run_q;
    to_d     = to_q;
    ito_d    = ito_q;
    cont_d   = cont_q;
    load_d   = wr_period;

    if (wr_control) begin
      ito_d   = wdata_i[CTRL_ITO_BIT];
      cont_d  = wdata_i[CTRL_CONT_BIT];
      presc_d = wdata_i[PRESC_MSB:PRESC_LSB];
    end
    if (wr_period) period_d = wdata_i[CNT_W-1:0];
    if (wr_snap)   snap_d   = cnt_q;

    // A PERIOD write lands in the counter one cycle later, after period_q has settled.
    if (load_q)       cnt_d = period_q;
    else if (timeout) cnt_d = period_q;
    else if (tick)    cnt_d = cnt_q - CNT_W'(1);

    if (start || wr_period || tick) pcnt_d = '0;
    else if (run_q)                 pcnt_d = pcnt_q + PRESC_W'(1);

    if (wr_period)                run_d = 1'b0;
    else if (start)               run_d = 1'b1;
    else if (stop)                run_d = 1'b0;
    else if (timeout && !cont_q)  run_d = 1'b0;

    // A timeout in the same cycle as a STATUS write must not be lost.
    if (timeout)        to_d = 1'b1;
    else if (wr_status) to_d = 1'b0;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q    <= RST_VAL;
      period_q <= RST_VAL;
      snap_q   <= '0;
      presc_q  <= '0;
      pcnt_q   <= '0;
      run_q    <= 1'b0;
      to_q     <= 1'b0;
      ito_q    <= 1'b0;
      cont_q   <= 1'b0;
      load_q   <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      period_q <= period_d;
      snap_q   <= snap_d;
      presc_q  <= presc_d;
      pcnt_q   <= pcnt_d;
      run_q    <= run_d;
      to_q     <= to_d;
      ito_q    <= ito_d;
      cont_q   <= cont_d;
      load_q   <= load_d;
    end
  end

  assign state_o.to    = to_q;
  assign state_o.run   = run_q;
  assign state_o.ito   = ito_q;
  assign state_o.cont  = cont_q;
  assign state_o.presc = presc_q;
  assign period_o      = period_q;
  assign snap_o        = snap_q;
  assign irq_o         = to_q & ito_q;

endmodule

// File: rtl/avalon_multi_timer.sv
// Avalon-MM slave with NUM_CH independent timers: address decode, registered read mux,
// global IRQ_PEND register and the OR-reduced level interrupt.
module avalon_multi_timer
  import amt_pkg::*;
#(
  parameter int  NUM_CH     = 4,
  parameter int  CNT_W      = 32,
  parameter int  RST_PERIOD = 49999,
  localparam int ADDR_W     = $clog2(NUM_CH + 1) + 2
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [ADDR_W-1:0] address,
  input  logic              chipselect,
  input  logic              write_n,
  input  logic [31:0]       writedata,
  output logic [31:0]       readdata,
  output logic              irq
);

  localparam int SEL_W = ADDR_W - 2;
  localparam logic [ADDR_W-1:0] IRQ_ADDR = ADDR_W'(4 * NUM_CH);

  logic [SEL_W-1:0] ch_sel;
  reg_off_e         off;
  logic             wr_en;

  ch_state_t        ch_state  [NUM_CH];
  logic [CNT_W-1:0] ch_period [NUM_CH];
  logic [CNT_W-1:0] ch_snap   [NUM_CH];
  logic [NUM_CH-1:0] ch_irq;

  logic [31:0] rd_data;
  logic [31:0] readdata_q;

  assign ch_sel = address[ADDR_W-1:2];
  assign off    = reg_off_e'(address[1:0]);
  assign wr_en  = chipselect && !write_n;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    amt_channel #(
      .CNT_W      (CNT_W),
      .RST_PERIOD (RST_PERIOD)
    ) u_ch (
      .clk_i    (clk),
      .rst_ni   (reset_n),
      .wr_i     (wr_en && (ch_sel == SEL_W'(g))),
      .off_i    (off),
      .wdata_i  (writedata),
      .state_o  (ch_state[g]),
      .period_o (ch_period[g]),
      .snap_o   (ch_snap[g]),
      .irq_o    (ch_irq[g])
    );
  end

  // Anything not matching a channel slot or IRQ_PEND reads back as zero.
  always_comb begin
    rd_data = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (ch_sel == SEL_W'(i)) begin
        case (off)
          REG_STATUS:  rd_data = pack_status(ch_state[i]);
          REG_CONTROL: rd_data = pack_control(ch_state[i]);
          REG_PERIOD:  rd_data = 32'(ch_period[i]);
          REG_SNAP:    rd_data = 32'(ch_snap[i]);
          default:     rd_data = '0;
        endcase
      end
    end
    if (address == IRQ_ADDR) rd_data = 32'(ch_irq);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) readdata_q <= '0;
    else          readdata_q <= chipselect ? rd_data : '0;
  end

  assign readdata = readdata_q;
  assign irq      = |ch_irq;

endmodule
